// File: rtl/fb_line_scheduler_if.sv
// Framebuffer memory bus plus host write port shared by the line scheduler
// (master) and the memory/host side (slave).
interface fb_line_scheduler_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    // Host handshake: a write transfers on any cycle where host_valid and
    // host_ready are both high; host_ready never waits on host_valid.
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              host_valid;
    logic              host_ready;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_data;

    modport master (
        output mem_en, mem_we, mem_addr, mem_wdata, host_ready,
        input  mem_rdata, host_valid, host_addr, host_data
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_wdata, host_ready,
        output mem_rdata, host_valid, host_addr, host_data
    );
endinterface

// File: rtl/fb_line_scheduler.sv
// Shares a single-port framebuffer between next-line prefetch into a ping-pong
// line buffer and host writes; scans out a 2x pixel-doubled image.
module fb_line_scheduler #(
    parameter int FB_W    = 320,
    parameter int FB_H    = 240,
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 8,
    parameter int VPIXELS = 480,
    parameter int VMAX    = 499
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       hcount,
    input  logic [10:0]       vcount,
    input  logic              picture,
    output logic [DATA_W-1:0] pix_out,
    output logic              underrun,
    output logic [1:0]        dbg_state,
    fb_line_scheduler_if.master bus
);
    localparam int CNT_W = $clog2(FB_W + 1);
    localparam int IDX_W = $clog2(FB_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              line_start;
    logic              fetch_pending;
    logic [10:0]       nl;
    logic [9:0]        hx;
    logic [ADDR_W-1:0] base;
    logic              host_ready;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              bank_q, bank_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rd_pend_q, rd_pend_d;
    logic [IDX_W-1:0]  rd_off_q, rd_off_d;
    logic              lb_we_q, lb_we_d;
    logic [IDX_W-1:0]  lb_idx_q, lb_idx_d;
    logic              lb_bank_q, lb_bank_d;
    logic [DATA_W-1:0] pix_q, pix_d;
    logic              underrun_q, underrun_d;

    logic [DATA_W-1:0] lbuf_q [2][FB_W];

    always_comb begin
        line_start    = (hcount == 11'd0);
        nl            = (vcount == 11'(VMAX)) ? 11'd0 : vcount + 11'd1;
        fetch_pending = line_start && (nl < 11'(VPIXELS)) && ({1'b0, nl[10:1]} < 11'(FB_H));
        base          = ADDR_W'(nl[10:1]) * ADDR_W'(FB_W);
        hx            = hcount[10:1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A line start always wins: restart on a pending fetch, otherwise abandon.
    always_comb begin
        state_d = state_q;
        if (fetch_pending) begin
            state_d = S_FETCH;
        end else if (line_start && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_FETCH: if (cnt_q == CNT_W'(FB_W)) state_d = S_DRAIN;
                S_DRAIN: state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        host_ready  = (state_q == S_IDLE) && !reset && !fetch_pending;
        cnt_d       = cnt_q;
        base_d      = base_q;
        bank_d      = bank_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_pend_d   = 1'b0;
        rd_off_d    = rd_off_q;
        if (fetch_pending) begin
            base_d     = base;
            bank_d     = nl[0];
            cnt_d      = CNT_W'(1);
            mem_en_d   = 1'b1;
            mem_addr_d = base;
            rd_pend_d  = 1'b1;
            rd_off_d   = '0;
        end else if ((state_q == S_FETCH) && !line_start && (cnt_q != CNT_W'(FB_W))) begin
            cnt_d      = cnt_q + CNT_W'(1);
            mem_en_d   = 1'b1;
            mem_addr_d = base_q + ADDR_W'(cnt_q);
            rd_pend_d  = 1'b1;
            rd_off_d   = cnt_q[IDX_W-1:0];
        end else if (host_ready && bus.host_valid) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = bus.host_addr;
            mem_wdata_d = bus.host_data;
        end
        // Read data returns one cycle after issue, so the write index trails by one.
        lb_we_d    = rd_pend_q;
        lb_idx_d   = rd_off_q;
        lb_bank_d  = bank_q;
        underrun_d = underrun_q || (line_start && (state_q != S_IDLE));
        pix_d      = '0;
        if (picture && (hx < 10'(FB_W))) begin
            pix_d = lbuf_q[vcount[0]][hx[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            base_q      <= '0;
            bank_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_off_q    <= '0;
            lb_we_q     <= 1'b0;
            lb_idx_q    <= '0;
            lb_bank_q   <= 1'b0;
            pix_q       <= '0;
            underrun_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            bank_q      <= bank_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_pend_q   <= rd_pend_d;
            rd_off_q    <= rd_off_d;
            lb_we_q     <= lb_we_d;
            lb_idx_q    <= lb_idx_d;
            lb_bank_q   <= lb_bank_d;
            pix_q       <= pix_d;
            underrun_q  <= underrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lb_we_q) begin
            lbuf_q[lb_bank_q][lb_idx_q] <= bus.mem_rdata;
        end
    end

    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.host_ready = host_ready;
    assign pix_out        = pix_q;
    assign underrun       = underrun_q;
    assign dbg_state      = state_q;
endmodule
